// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shiftreg serial link (receiver and transmitter).
package shiftreg_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;
endpackage

// File: rtl/shiftreg_rx_if.sv
// Parallel-side valid/ready bus of the shiftreg receiver.
interface shiftreg_rx_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready;

  modport master (output parallel_out, output out_valid, input  out_ready);
  modport slave  (input  parallel_out, input  out_valid, output out_ready);
endinterface

// File: rtl/shiftreg_rx_outbuf.sv
// One-entry valid/ready holding register with sticky overrun reporting.
module shiftreg_rx_outbuf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;
  logic             w_xfer;
  logic             w_drop;

  assign w_xfer = r_valid & i_ready;
  assign w_drop = i_load & r_valid & ~i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // A slot emptied this cycle can be refilled in the same cycle.
      if (i_load && (!r_valid || i_ready)) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_drop)      r_ovr <= 1'b1;
      else if (w_xfer) r_ovr <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;
endmodule

// File: rtl/shiftreg_rx.sv
// Serial-to-parallel receiver: start-framed WIDTH-bit words, MSB- or LSB-first,
// delivered through a one-entry valid/ready buffer.
module shiftreg_rx
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          direction,
  input  logic          serial_in,
  input  logic          start,
  output logic          busy,
  output logic          overrun,
  output logic          frame_err,
  shiftreg_rx_if.master bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_dir;
  logic             r_ferr;

  logic             w_new;
  logic             w_cap;
  logic             w_done;
  logic             w_dir;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_new  = enable & start;
  assign w_cap  = enable & (start | (r_state == SHIFT));
  assign w_done = enable & ~start & (r_state == SHIFT) & (r_cnt == LAST);

  // Bit 0 of a word uses the live direction input and a cleared shifter,
  // so leftovers of an aborted word never leak into the new one.
  assign w_dir  = w_new ? direction : r_dir;
  assign w_base = w_new ? '0 : r_shift;
  assign w_shift_nxt = (w_dir == DIR_MSB_FIRST) ? {w_base[WIDTH-2:0], serial_in}
                                                : {serial_in, w_base[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_dir   <= DIR_MSB_FIRST;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= w_new & (r_state == SHIFT);
      if (w_cap) r_shift <= w_shift_nxt;
      if (w_new) begin
        r_dir   <= direction;
        r_cnt   <= CW'(1);
        r_state <= SHIFT;
      end else if (w_cap) begin
        if (w_done) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy      = (r_state == SHIFT);
  assign frame_err = r_ferr;

  shiftreg_rx_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_done),
    .i_data   (w_shift_nxt),
    .i_ready  (bus.out_ready),
    .o_data   (bus.parallel_out),
    .o_valid  (bus.out_valid),
    .o_overrun(overrun)
  );
endmodule

// File: tb/tb_shiftreg_rx.sv
// Randomized + directed bench for shiftreg_rx with a bit-list reference model
// and a queue scoreboard drained by an independent output monitor.
module tb_shiftreg_rx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n, enable, direction, serial_in, start;
  logic busy, overrun, frame_err;

  shiftreg_rx_if #(.WIDTH(W)) bus_if ();

  shiftreg_rx #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .direction(direction),
    .serial_in(serial_in),
    .start    (start),
    .busy     (busy),
    .overrun  (overrun),
    .frame_err(frame_err),
    .bus      (bus_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] expq[$];
  bit           mbits[$];
  bit           mdir, mvalid, movr, mferr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word value from the received bit sequence: first bit lands at the MSB
  // (MSB first) or at bit 0 (LSB first).
  function automatic logic [W-1:0] mk_word(input bit q[$], input bit d);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (d) w[W-1-i] = q[i];
      else   w[i]     = q[i];
    end
    return w;
  endfunction

  // One clock: drive inputs, advance the model, then compare status flags.
  task automatic cyc(input bit en, input bit st, input bit b, input bit d, input bit rdy);
    bit           done = 0;
    bit           xfer;
    logic [W-1:0] w = '0;
    enable = en; start = st; serial_in = b; direction = d; bus_if.out_ready = rdy;
    mferr = 0;
    if (en) begin
      if (st) begin
        if (mbits.size() > 0) mferr = 1;
        mbits = {b};
        mdir  = d;
      end else if (mbits.size() > 0) begin
        mbits.push_back(b);
        if (mbits.size() == W) begin
          w = mk_word(mbits, mdir);
          done = 1;
          mbits = {};
        end
      end
    end
    xfer = mvalid & rdy;
    if (done && mvalid && !rdy) movr = 1;
    else if (xfer)              movr = 0;
    if (done && (!mvalid || rdy)) begin
      expq.push_back(w);
      mvalid = 1;
    end else if (xfer) begin
      mvalid = 0;
    end
    @(posedge clk); #1;
    chk("busy", busy, (mbits.size() > 0));
    chk("out_valid", bus_if.out_valid, mvalid);
    chk("overrun", overrun, movr);
    chk("frame_err", frame_err, mferr);
  endtask

  task automatic word4(input logic [W-1:0] seq, input bit d, input bit rdy);
    for (int i = 0; i < W; i++) cyc(1, i == 0, seq[W-1-i], d, rdy);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out", bus_if.parallel_out, 0);
    chk("rst_valid", bus_if.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    mbits = {}; expq = {}; mvalid = 0; movr = 0; mferr = 0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  // Monitor: each cycle with valid & ready at the falling edge is one transfer.
  always @(negedge clk) begin
    if (reset_n && bus_if.out_valid && bus_if.out_ready) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus_if.parallel_out);
      end else begin
        chk("word", bus_if.parallel_out, expq.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 0; start = 0; serial_in = 0; direction = 1;
    bus_if.out_ready = 0;
    mdir = 1; mvalid = 0; movr = 0; mferr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", bus_if.out_valid, 0);
    chk("reset_out", bus_if.parallel_out, 0);
    reset_n = 1'b1;

    word4(4'b1010, 1, 1);
    chk("msb_first", bus_if.parallel_out, 4'b1010);
    cyc(0, 0, 0, 1, 1);
    word4(4'b1010, 0, 1);
    chk("lsb_first", bus_if.parallel_out, 4'b0101);
    // direction toggled mid-word: latched value governs the whole word
    cyc(1, 1, 1, 1, 1); cyc(1, 0, 1, 0, 1); cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 1, 1);
    chk("dir_latched", bus_if.parallel_out, 4'b1100);
    // three-cycle enable gap between bits 2 and 3
    cyc(1, 1, 1, 1, 1); cyc(1, 0, 0, 1, 1);
    repeat (3) begin cyc(0, 0, 1, 1, 1); chk("gap_busy", busy, 1); end
    cyc(1, 0, 1, 1, 1); cyc(1, 0, 0, 1, 1);
    chk("gap_word", bus_if.parallel_out, 4'b1010);
    // overrun: two words while the consumer stalls
    word4(4'b1010, 1, 0);
    word4(4'b0011, 1, 0);
    chk("ovr_hold", bus_if.parallel_out, 4'b1010);
    chk("ovr_flag", overrun, 1);
    cyc(0, 0, 0, 1, 1);
    chk("ovr_clear", overrun, 0);
    // restart at bit 2
    cyc(1, 1, 1, 1, 1); cyc(1, 0, 0, 1, 1);
    cyc(1, 1, 1, 1, 1);
    chk("ferr_pulse", frame_err, 1);
    cyc(1, 0, 1, 1, 1); cyc(1, 0, 0, 1, 1); cyc(1, 0, 0, 1, 1);
    chk("restart_word", bus_if.parallel_out, 4'b1100);
    chk("ferr_gone", frame_err, 0);
    // reset mid-word, then with a word buffered
    cyc(1, 1, 1, 1, 0); cyc(1, 0, 1, 1, 0);
    do_reset();
    word4(4'b0110, 1, 0);
    do_reset();
    word4(4'b1001, 0, 1);
    chk("post_reset", bus_if.parallel_out, 4'b1001);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bit en, st;
      en = ($urandom_range(0, 3) != 0);
      st = (mbits.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(en, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) != 0));
    end

    repeat (3) cyc(0, 0, 0, 1, 1);
    chk("drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
